// File: rtl/instr_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder_pkg
// Description : Shared miss-interface geometry and responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_responder_pkg;

  localparam int WORD_WIDTH          = 20;
  localparam int BEAT_WIDTH          = 40;
  localparam int WORDS_PER_BLOCK     = 16;
  localparam int BEATS_PER_BLOCK     = 8;
  localparam int B_OFFSET_BITS_WIDTH = 4;
  localparam int MEM_IF_ADDR         = 16;

  localparam int BLOCK_BASE_WIDTH = MEM_IF_ADDR - B_OFFSET_BITS_WIDTH;
  localparam int BEAT_IDX_WIDTH   = $clog2(BEATS_PER_BLOCK);
  localparam int LAT_CNT_WIDTH    = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_STREAM = 2'd2;

  // Word address of the even (odd=0) or odd (odd=1) half of a beat.
  function automatic logic [MEM_IF_ADDR-1:0] beat_word_addr(
    input logic [BLOCK_BASE_WIDTH-1:0] base,
    input logic [BEAT_IDX_WIDTH-1:0]   beat,
    input logic                        odd
  );
    return {base, beat, odd};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_array
// Description : Word storage, one synchronous write port, two async reads.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
  parameter int INDEX_WIDTH = 10,
  parameter int DATA_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx_even,
  output logic [DATA_WIDTH-1:0]  o_rd_data_even,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx_odd,
  output logic [DATA_WIDTH-1:0]  o_rd_data_odd
);

  localparam int c_depth = 1 << INDEX_WIDTH;

  // Contents are deliberately left unreset; they are loaded through the write port.
  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data_even = r_mem[i_rd_idx_even];
  assign o_rd_data_odd  = r_mem[i_rd_idx_odd];

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Miss-interface memory responder: latency wait, 8-beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int MEM_INDEX_WIDTH = 10,
  parameter int READ_LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   i_halt,
  input  logic [MEM_IF_ADDR-1:0] i_req_addr,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  output logic [BEAT_WIDTH-1:0]  o_data,
  output logic                   o_data_valid,
  input  logic                   i_data_ready,
  input  logic                   i_wr_en,
  input  logic [MEM_IF_ADDR-1:0] i_wr_addr,
  input  logic [WORD_WIDTH-1:0]  i_wr_data
);

  localparam logic [LAT_CNT_WIDTH-1:0]  c_lat_init  = LAT_CNT_WIDTH'(READ_LATENCY - 1);
  localparam logic [BEAT_IDX_WIDTH-1:0] c_last_beat = BEAT_IDX_WIDTH'(BEATS_PER_BLOCK - 1);

  state_t                      r_state;
  logic [LAT_CNT_WIDTH-1:0]    r_lat_cnt;
  logic [BEAT_IDX_WIDTH-1:0]   r_beat_cnt;
  logic [BLOCK_BASE_WIDTH-1:0] r_base;

  logic                        w_idle;
  logic                        w_wr_fire;
  logic [BEAT_IDX_WIDTH-1:0]   w_rd_beat;
  logic [MEM_IF_ADDR-1:0]      w_rd_addr_even;
  logic [MEM_IF_ADDR-1:0]      w_rd_addr_odd;
  logic [WORD_WIDTH-1:0]       w_rd_even;
  logic [WORD_WIDTH-1:0]       w_rd_odd;
  logic                        w_unused_bits;

  assign w_idle      = (r_state == S_IDLE);
  assign o_req_ready = w_idle & ~i_halt;
  assign w_wr_fire   = i_wr_en & w_idle & ~i_halt;

  // Read ports always present the beat that the next load edge will capture.
  assign w_rd_beat      = (r_state == S_STREAM) ? r_beat_cnt + 1'b1 : '0;
  assign w_rd_addr_even = beat_word_addr(r_base, w_rd_beat, 1'b0);
  assign w_rd_addr_odd  = beat_word_addr(r_base, w_rd_beat, 1'b1);

  instr_mem_array #(
    .INDEX_WIDTH (MEM_INDEX_WIDTH),
    .DATA_WIDTH  (WORD_WIDTH)
  ) u_mem (
    .clk            (clk),
    .i_wr_en        (w_wr_fire),
    .i_wr_idx       (i_wr_addr[MEM_INDEX_WIDTH-1:0]),
    .i_wr_data      (i_wr_data),
    .i_rd_idx_even  (w_rd_addr_even[MEM_INDEX_WIDTH-1:0]),
    .o_rd_data_even (w_rd_even),
    .i_rd_idx_odd   (w_rd_addr_odd[MEM_INDEX_WIDTH-1:0]),
    .o_rd_data_odd  (w_rd_odd)
  );

  // Address bits above the storage index alias; the block offset is discarded.
  assign w_unused_bits = ^{i_req_addr[B_OFFSET_BITS_WIDTH-1:0],
                           i_wr_addr[MEM_IF_ADDR-1:MEM_INDEX_WIDTH],
                           w_rd_addr_even[MEM_IF_ADDR-1:MEM_INDEX_WIDTH],
                           w_rd_addr_odd[MEM_IF_ADDR-1:MEM_INDEX_WIDTH]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_beat_cnt   <= '0;
      r_base       <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else if (!i_halt) begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_base     <= i_req_addr[MEM_IF_ADDR-1:B_OFFSET_BITS_WIDTH];
            r_lat_cnt  <= c_lat_init;
            r_beat_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            o_data       <= {w_rd_odd, w_rd_even};
            o_data_valid <= 1'b1;
            r_beat_cnt   <= '0;
            r_state      <= S_STREAM;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_STREAM: begin
          if (o_data_valid && i_data_ready) begin
            if (r_beat_cnt == c_last_beat) begin
              o_data_valid <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              o_data     <= {w_rd_odd, w_rd_even};
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          o_data_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
